// File: rtl/data_consuming_block.sv
// Stream sink/checker: buffers valid/ready words in a small FIFO and checks they form a +1 sequence.
// Latency: push to out_valid is 1 cycle when empty; out_data is always a registered head, with no fall-through.
// Backpressure: ready_out = not full, from registered state only; with BACKPRESSURE_EN it also drops one cycle in every STALL_PERIOD.
module data_consuming_block #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 16,
    parameter int STALL_PERIOD = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              clear_err,
    output logic              err_flag,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  rx_count,
    output logic              locked
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;

    typedef enum logic {SYNC, TRACK} state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nxt;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] expected_q, expected_d;
    logic              err_flag_q, err_flag_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [CNT_W-1:0]  rx_count_q, rx_count_d;
    logic              push, pop, err_evt;
    logic              not_full;

    assign not_full   = (fill_q != FILL_W'(FIFO_DEPTH));
    assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

`ifdef BACKPRESSURE_EN
    localparam int STALL_W = $clog2(STALL_PERIOD);
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q + STALL_W'(1);
        if (stall_q == STALL_W'(STALL_PERIOD - 1)) begin
            stall_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign ready_out = not_full && (stall_q != STALL_W'(STALL_PERIOD - 1));
`else
    assign ready_out = not_full;
`endif

    assign push      = valid_in && ready_out;
    assign pop       = out_valid && out_ready;
    assign out_valid = (fill_q != '0);
    assign out_data  = out_data_q;
    assign err_flag  = err_flag_q;
    assign err_count = err_count_q;
    assign rx_count  = rx_count_q;
    assign locked    = (state_q == TRACK);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        out_data_d = out_data_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_nxt;
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
        // The head register must pick up a word written this cycle when it becomes the head.
        if (push && (fill_q == '0)) begin
            out_data_d = data_in;
        end else if (pop && (fill_q > FILL_W'(1))) begin
            out_data_d = mem_q[rd_ptr_nxt];
        end else if (pop && push) begin
            out_data_d = data_in;
        end
    end

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        err_evt    = 1'b0;
        if (push) begin
            case (state_q)
                SYNC: begin
                    expected_d = data_in + DATA_W'(1);
                    state_d    = TRACK;
                end
                TRACK: begin
                    if (data_in == expected_q) begin
                        expected_d = expected_q + DATA_W'(1);
                    end else begin
                        err_evt    = 1'b1;
                        expected_d = data_in + DATA_W'(1);
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    always_comb begin
        err_flag_d  = err_flag_q;
        err_count_d = err_count_q;
        rx_count_d  = rx_count_q;
        if (push) begin
            rx_count_d = rx_count_q + CNT_W'(1);
        end
        if (clear_err) begin
            err_flag_d  = 1'b0;
            err_count_d = '0;
        end else if (err_evt) begin
            err_flag_d = 1'b1;
            if (err_count_q != '1) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: fill and pointers decide which entries are meaningful.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            state_q     <= SYNC;
            expected_q  <= '0;
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
            rx_count_q  <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            state_q     <= state_d;
            expected_q  <= expected_d;
            err_flag_q  <= err_flag_d;
            err_count_q <= err_count_d;
            rx_count_q  <= rx_count_d;
        end
    end
endmodule

// File: tb/tb_data_consuming_block.sv
// Randomized scoreboard bench for data_consuming_block: driver updates a queue-based model, monitor compares on negedge.
module tb_data_consuming_block;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic       out_ready = 1'b0;
    logic       clear_err = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready_out, out_valid, err_flag, locked;
    logic [7:0] out_data;
    logic [15:0] err_count, rx_count;

    data_consuming_block #(
        .DATA_W(8), .FIFO_DEPTH(4), .CNT_W(16), .STALL_PERIOD(5)
    ) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .ready_out(ready_out), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .clear_err(clear_err), .err_flag(err_flag), .err_count(err_count),
        .rx_count(rx_count), .locked(locked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state (values after the most recent rising edge)
    logic [7:0] exp_q[$];
    int         mfill = 0;
    int         mstall = 0;
    int         mrx = 0;
    int         merr = 0;
    bit         mflag = 0;
    bit         mlocked = 0;
    logic [7:0] mexp = 0;
    logic [7:0] mlast = 0;
    bit         mon_en = 0;

    // Transfer planned for the coming edge
    bit         p_rst, p_push, p_pop, p_clr;
    logic [7:0] p_data;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        bit r;
        r = (mfill < 4);
`ifdef BACKPRESSURE_EN
        if (mstall == 4) r = 0;
`endif
        return r;
    endfunction

    task automatic commit();
        if (p_rst) begin
            mfill = 0; mstall = 0; mrx = 0; merr = 0; mflag = 0;
            mlocked = 0; mexp = 0; mlast = 0;
            exp_q.delete();
        end else begin
            bit err;
            err = 0;
            if (p_push) begin
                mrx = (mrx + 1) % 65536;
                if (mlocked && p_data != mexp) err = 1;
                mlocked = 1;
                mexp = p_data + 8'd1;
                exp_q.push_back(p_data);
            end
            if (p_clr) begin
                mflag = 0; merr = 0;
            end else if (err) begin
                mflag = 1;
                if (merr != 65535) merr++;
            end
            mfill = mfill + int'(p_push) - int'(p_pop);
            mstall = (mstall + 1) % 5;
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit ordy,
                         input bit clr, input bit r, output bit acc);
        valid_in  = v;
        data_in   = d;
        out_ready = ordy;
        clear_err = clr;
        rst       = r;
        p_rst  = r;
        p_push = !r && v && m_ready();
        p_pop  = !r && (mfill > 0) && ordy;
        p_clr  = clr;
        p_data = d;
        acc    = p_push;
        @(posedge clk);
        #2;
        commit();
    endtask

    task automatic send(input logic [7:0] d, input bit ordy, input bit clr);
        bit acc;
        int n;
        n = 0;
        do begin
            drive(1'b1, d, ordy, clr, 1'b0, acc);
            n++;
        end while (!acc && n < 40);
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout word=%0d not accepted within 40 cycles", d);
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, ordy, 1'b0, 1'b0, acc);
    endtask

    // Monitor: compares DUT outputs to the model and pops the scoreboard on output handshakes.
    always @(negedge clk) begin
        if (mon_en) begin
            check("ready_out", int'(ready_out), int'(m_ready()));
            check("out_valid", int'(out_valid), int'(mfill != 0));
            check("rx_count", int'(rx_count), mrx);
            check("err_count", int'(err_count), merr);
            check("err_flag", int'(err_flag), int'(mflag));
            check("locked", int'(locked), int'(mlocked));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 1, 0);
                end else begin
                    check("out_data", int'(out_data), int'(exp_q[0]));
                    if (out_ready && !rst) begin
                        mlast = exp_q[0];
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("out_data_hold", int'(out_data), int'(mlast));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bit hold;
        bit v, ordy, clr;
        logic [7:0] w;

        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        mon_en = 1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

        // Straight 0..9 with the sink always ready
        for (int i = 0; i < 10; i++) send(8'(i), 1'b1, 1'b0);
        idle(3, 1'b1);

        // Fill to full, hold a word on a stalled input, then free one slot
        for (int i = 16; i < 20; i++) send(8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h14, 1'b0, 1'b0, 1'b0, acc);
        drive(1'b1, 8'h14, 1'b1, 1'b0, 1'b0, acc);
        send(8'h14, 1'b0, 1'b0);
        idle(6, 1'b1);

        // Gap 0x06 -> 0x08; clear on the first push also tests clear-over-error priority
        send(8'h05, 1'b1, 1'b1);
        send(8'h06, 1'b1, 1'b0);
        send(8'h08, 1'b1, 1'b0);
        send(8'h09, 1'b1, 1'b0);
        idle(2, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, acc);
        idle(2, 1'b1);

        // Wrap through 0xFF
        send(8'hFE, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b0);
        send(8'h00, 1'b1, 1'b0);
        send(8'h01, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Reset with three words buffered
        send(8'h20, 1'b0, 1'b0);
        send(8'h21, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
        send(8'h40, 1'b1, 1'b0);
        send(8'h41, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Random traffic: gaps, sink stalls, occasional jumps, clears and resets
        w = 8'($urandom);
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            v    = hold || ($urandom % 4 != 0);
            ordy = ($urandom % 4 != 0);
            clr  = ($urandom % 60 == 0);
            if (!hold && $urandom % 700 == 0) begin
                drive(1'b0, 8'h00, ordy, 1'b0, 1'b1, acc);
            end else begin
                drive(v, w, ordy, clr, 1'b0, acc);
                hold = v && !acc;
                if (acc) w = ($urandom % 10 == 0) ? 8'($urandom) : w + 8'd1;
            end
        end

        idle(10, 1'b1);
        check("drain_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
